// File: rtl/inner_dot_collect.sv
// inner_dot_collect: realigns issue tags with the inner-dot engine output,
// quantizes conv results to int8 and accumulates the three FC partial dots.
// Ports: clk, rst_n (async, active-low); in_vld/cnt issue tags; dot engine
// result; err_clr clears fc_err. Outputs: conv_vld/conv_q/conv_cnt int8 conv
// stream; fc_vld/fc_sum fully-connected sum; fc_err sticky sequencing error.
module inner_dot_collect #(
    parameter int SUM_WIDTH = 21,
    parameter int DOT_LAT   = 2,
    parameter int SHIFT     = 4,
    parameter int RELU      = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_vld,
    input  logic [6:0]                  cnt,
    input  logic signed [SUM_WIDTH-1:0] dot,
    input  logic                        err_clr,
    output logic                        conv_vld,
    output logic signed [7:0]           conv_q,
    output logic [6:0]                  conv_cnt,
    output logic                        fc_vld,
    output logic signed [SUM_WIDTH+1:0] fc_sum,
    output logic                        fc_err
);

    localparam int AW = SUM_WIDTH + 2;
    localparam logic signed [SUM_WIDTH-1:0] QMAX = SUM_WIDTH'(127);
    localparam logic signed [SUM_WIDTH-1:0] QMIN = SUM_WIDTH'(-128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } fc_state_e;

    // Tag pipeline: valid bits are reset, counts are don't-care while invalid.
    logic [DOT_LAT-1:0] tvld_q;
    logic [6:0]         tcnt_q [DOT_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvld_q <= '0;
        end else begin
            tvld_q[0] <= in_vld;
            for (int i = 1; i < DOT_LAT; i++) begin
                tvld_q[i] <= tvld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tcnt_q[0] <= cnt;
        for (int i = 1; i < DOT_LAT; i++) begin
            tcnt_q[i] <= tcnt_q[i-1];
        end
    end

    logic       t_vld;
    logic [6:0] t_cnt;
    logic       tag34, tag50, tag66, conv_slot;

    assign t_vld     = tvld_q[DOT_LAT-1];
    assign t_cnt     = tcnt_q[DOT_LAT-1];
    assign tag34     = t_vld && (t_cnt == 7'd34);
    assign tag50     = t_vld && (t_cnt == 7'd50);
    assign tag66     = t_vld && (t_cnt == 7'd66);
    assign conv_slot = t_vld && !(tag34 || tag50 || tag66);

    // Conv quantization: optional ReLU, arithmetic shift, int8 saturation.
    logic signed [SUM_WIDTH-1:0] relu_v, shr_v;
    logic signed [7:0]           sat_v;

    always_comb begin
        relu_v = dot;
        if ((RELU != 0) && (dot < 0)) begin
            relu_v = '0;
        end
        shr_v = relu_v >>> SHIFT;
        if (shr_v > QMAX) begin
            sat_v = 8'sd127;
        end else if (shr_v < QMIN) begin
            sat_v = -8'sd128;
        end else begin
            sat_v = shr_v[7:0];
        end
    end

    logic              conv_vld_q;
    logic signed [7:0] conv_q_q;
    logic [6:0]        conv_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_vld_q <= 1'b0;
            conv_q_q   <= '0;
            conv_cnt_q <= '0;
        end else begin
            conv_vld_q <= conv_slot;
            if (conv_slot) begin
                conv_q_q   <= sat_v;
                conv_cnt_q <= t_cnt;
            end
        end
    end

    // FC accumulation FSM.
    fc_state_e            state_q, state_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] fc_sum_q, fc_sum_d;
    logic                 fc_vld_q, fc_vld_d;
    logic                 fc_err_q, fc_err_d;
    logic                 err_set;
    logic signed [AW-1:0] dot_ext;

    assign dot_ext = {{2{dot[SUM_WIDTH-1]}}, dot};

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fc_sum_d = fc_sum_q;
        fc_vld_d = 1'b0;
        err_set  = 1'b0;
        if (tag34) begin
            acc_d   = dot_ext;
            state_d = P1;
            err_set = (state_q != IDLE);
        end else if (tag50) begin
            if (state_q == P1) begin
                acc_d   = acc_q + dot_ext;
                state_d = P2;
            end else begin
                err_set = 1'b1;
                state_d = IDLE;
            end
        end else if (tag66) begin
            if (state_q == P2) begin
                fc_sum_d = acc_q + dot_ext;
                fc_vld_d = 1'b1;
            end else begin
                err_set = 1'b1;
            end
            state_d = IDLE;
        end
        // A new error takes priority over a simultaneous clear.
        if (err_set) begin
            fc_err_d = 1'b1;
        end else if (err_clr) begin
            fc_err_d = 1'b0;
        end else begin
            fc_err_d = fc_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            fc_sum_q <= '0;
            fc_vld_q <= 1'b0;
            fc_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fc_sum_q <= fc_sum_d;
            fc_vld_q <= fc_vld_d;
            fc_err_q <= fc_err_d;
        end
    end

    assign conv_vld = conv_vld_q;
    assign conv_q   = conv_q_q;
    assign conv_cnt = conv_cnt_q;
    assign fc_vld   = fc_vld_q;
    assign fc_sum   = fc_sum_q;
    assign fc_err   = fc_err_q;

endmodule

// File: tb/tb_inner_dot_collect.sv
// Scoreboard bench for inner_dot_collect (DOT_LAT=2, SHIFT=4).
// A ReLU and a non-ReLU instance share stimulus; monitors pop expected results.
module tb_inner_dot_collect;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_vld;
    logic [6:0]         cnt;
    logic signed [20:0] dot;
    logic               err_clr;

    logic               conv_vld, fc_vld, fc_err;
    logic signed [7:0]  conv_q;
    logic [6:0]         conv_cnt;
    logic signed [22:0] fc_sum;

    logic               nr_conv_vld, nr_fc_vld, nr_fc_err;
    logic signed [7:0]  nr_conv_q;
    logic [6:0]         nr_conv_cnt;
    logic signed [22:0] nr_fc_sum;

    always #5 clk = ~clk;

    inner_dot_collect #(.SUM_WIDTH(21), .DOT_LAT(2), .SHIFT(4), .RELU(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .cnt(cnt), .dot(dot),
        .err_clr(err_clr), .conv_vld(conv_vld), .conv_q(conv_q),
        .conv_cnt(conv_cnt), .fc_vld(fc_vld), .fc_sum(fc_sum), .fc_err(fc_err)
    );

    inner_dot_collect #(.SUM_WIDTH(21), .DOT_LAT(2), .SHIFT(4), .RELU(0)) u_nr (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .cnt(cnt), .dot(dot),
        .err_clr(err_clr), .conv_vld(nr_conv_vld), .conv_q(nr_conv_q),
        .conv_cnt(nr_conv_cnt), .fc_vld(nr_fc_vld), .fc_sum(nr_fc_sum),
        .fc_err(nr_fc_err)
    );

    typedef struct {
        int q;
        int c;
    } conv_exp_t;

    conv_exp_t conv_sb[$];
    conv_exp_t nr_sb[$];
    int        fc_sb[$];

    int n_vec = 0;
    int n_bad = 0;
    int hist0 = 0;
    int hist1 = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: issue a tag now, deliver the dot issued two cycles ago.
    task automatic step(input logic v, input int c, input int d,
                        input logic clr);
        @(negedge clk);
        in_vld  = v;
        cnt     = 7'(c);
        dot     = 21'(hist1);
        err_clr = clr;
        hist1   = hist0;
        hist0   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic conv_vec(input int c, input int d,
                            input int eq, input int enr);
        conv_exp_t e;
        e.c = c;
        e.q = eq;
        conv_sb.push_back(e);
        e.q = enr;
        nr_sb.push_back(e);
        step(1'b1, c, d, 1'b0);
    endtask

    task automatic check_reset_outs(input string tag);
        cmp({tag, " conv_vld"}, int'(conv_vld), 0);
        cmp({tag, " conv_q"}, int'(conv_q), 0);
        cmp({tag, " conv_cnt"}, int'(conv_cnt), 0);
        cmp({tag, " fc_vld"}, int'(fc_vld), 0);
        cmp({tag, " fc_sum"}, int'(fc_sum), 0);
        cmp({tag, " fc_err"}, int'(fc_err), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (conv_vld && fc_vld) cmp("mutex conv/fc", 1, 0);
            if (conv_vld) begin
                if (conv_sb.size() == 0) begin
                    cmp("unexpected conv_vld", 1, 0);
                end else begin
                    conv_exp_t e;
                    e = conv_sb.pop_front();
                    cmp("conv_q", int'(conv_q), e.q);
                    cmp("conv_cnt", int'(conv_cnt), e.c);
                end
            end
            if (fc_vld) begin
                if (fc_sb.size() == 0) begin
                    cmp("unexpected fc_vld", 1, 0);
                end else begin
                    int e;
                    e = fc_sb.pop_front();
                    cmp("fc_sum", int'(fc_sum), e);
                end
            end
            if (nr_conv_vld) begin
                if (nr_sb.size() == 0) begin
                    cmp("unexpected nr conv_vld", 1, 0);
                end else begin
                    conv_exp_t e;
                    e = nr_sb.pop_front();
                    cmp("nr conv_q", int'(nr_conv_q), e.q);
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        cnt     = '0;
        dot     = '0;
        err_clr = 1'b0;
        #2;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Conv: basic, saturate high, ReLU / negative floor, saturate low.
        conv_vec(5, 1600, 100, 100);
        conv_vec(6, 5000, 127, 127);
        conv_vec(7, -300, 0, -19);
        conv_vec(8, -3000, 0, -128);
        idle(4);
        cmp("conv hold q", int'(conv_q), 0);
        cmp("conv hold cnt", int'(conv_cnt), 8);

        // FC sequence with an interleaved conv slot.
        step(1'b1, 34, 1000, 1'b0);
        conv_vec(40, 320, 20, 20);
        step(1'b1, 50, -200, 1'b0);
        fc_sb.push_back(850);
        step(1'b1, 66, 50, 1'b0);
        idle(4);
        cmp("fc_err after good seq", int'(fc_err), 0);

        // FC extremes.
        step(1'b1, 34, -1048576, 1'b0);
        step(1'b1, 50, -1048576, 1'b0);
        fc_sb.push_back(-3145728);
        step(1'b1, 66, -1048576, 1'b0);
        idle(4);
        cmp("fc_err after extremes", int'(fc_err), 0);

        // Sequencing error, clear, clear colliding with a new error.
        step(1'b1, 50, 7, 1'b0);
        idle(3);
        cmp("fc_err tag50 first", int'(fc_err), 1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        cmp("fc_err cleared", int'(fc_err), 0);
        step(1'b1, 66, 9, 1'b0);
        step(1'b0, 0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        cmp("fc_err clr vs err", int'(fc_err), 1);
        step(1'b0, 0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b0);
        cmp("fc_err cleared again", int'(fc_err), 0);

        // Reset in the middle of an FC sequence.
        step(1'b1, 34, 111, 1'b0);
        step(1'b1, 50, 222, 1'b0);
        idle(3);
        @(negedge clk);
        rst_n  = 1'b0;
        in_vld = 1'b0;
        hist0  = 0;
        hist1  = 0;
        #1;
        check_reset_outs("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 66, 333, 1'b0);
        idle(4);
        cmp("fc_err after reset 66", int'(fc_err), 1);

        cmp("conv scoreboard empty", conv_sb.size(), 0);
        cmp("nr scoreboard empty", nr_sb.size(), 0);
        cmp("fc scoreboard empty", fc_sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
